// File: rtl/global_buffer_pkg.sv
// Shared types and constants for the GLB config-chain master.
package global_buffer_pkg;

    localparam int unsigned GLB_CFG_NUM_REQ    = 2;
    localparam int unsigned GLB_CFG_ADDR_WIDTH = 12;
    localparam int unsigned GLB_CFG_DATA_WIDTH = 32;
    localparam int unsigned GLB_CFG_RD_TIMEOUT = 255;

    // One requester's command as seen by the chain master
    typedef struct packed {
        logic                          write;
        logic [GLB_CFG_ADDR_WIDTH-1:0] addr;
        logic [GLB_CFG_DATA_WIDTH-1:0] wdata;
    } glb_cfg_req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DONE = 2'd1,
        RD_WAIT = 2'd2
    } glb_cfg_mst_state_e;

    // Requester index to one-hot requester vector
    function automatic logic [GLB_CFG_NUM_REQ-1:0] glb_cfg_onehot(input logic idx);
        return GLB_CFG_NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/glb_cfg_rr_arbiter.sv
// Two-way round-robin arbiter: holds the priority pointer, picks the grant
// and produces the one-hot ready for the accepted requester.
module glb_cfg_rr_arbiter
    import global_buffer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [GLB_CFG_NUM_REQ-1:0] req_valid,
    output logic [GLB_CFG_NUM_REQ-1:0] req_ready_c,
    output logic                       grant_c,
    output logic                       accept_c
);

    logic rr_ptr;
    logic grant_valid;

    // Pointer requester first, otherwise the other one
    always_comb begin
        grant_c     = rr_ptr;
        grant_valid = 1'b0;
        if (req_valid[rr_ptr]) begin
            grant_c     = rr_ptr;
            grant_valid = 1'b1;
        end else if (req_valid[~rr_ptr]) begin
            grant_c     = ~rr_ptr;
            grant_valid = 1'b1;
        end
    end

    assign accept_c    = enable & grant_valid;
    assign req_ready_c = accept_c ? glb_cfg_onehot(grant_c) : '0;

    // Hand priority to the other requester after every accept
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (accept_c) begin
            rr_ptr <= ~grant_c;
        end
    end

endmodule

// File: rtl/glb_cfg_chain_master.sv
// Drives the west end of the GLB tile config chain on behalf of two
// requesters; one transaction in flight, read timeout, one-cycle responses.
module glb_cfg_chain_master
    import global_buffer_pkg::*;
#(
    parameter int unsigned NUM_REQ    = GLB_CFG_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = GLB_CFG_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = GLB_CFG_DATA_WIDTH,
    parameter int unsigned RD_TIMEOUT = GLB_CFG_RD_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [DATA_WIDTH-1:0]        resp_rdata,
    output logic                         resp_err,
    output logic                         cfg_wr_en,
    output logic [ADDR_WIDTH-1:0]        cfg_wr_addr,
    output logic [DATA_WIDTH-1:0]        cfg_wr_data,
    output logic                         cfg_rd_en,
    output logic [ADDR_WIDTH-1:0]        cfg_rd_addr,
    output logic                         cfg_wr_clk_en,
    output logic                         cfg_rd_clk_en,
    input  logic [DATA_WIDTH-1:0]        cfg_rd_data,
    input  logic                         cfg_rd_data_valid
);

    localparam int unsigned TMO_W = $clog2(RD_TIMEOUT + 1);

    glb_cfg_mst_state_e state;
    logic               gnt_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               grant_c;
    logic               accept_c;
    glb_cfg_req_t       sel_req_c;

    assign cfg_wr_clk_en = 1'b1;
    assign cfg_rd_clk_en = 1'b1;

    // Requests are only taken in IDLE and never while reset is applied
    glb_cfg_rr_arbiter u_arb (
        .clk         (clk),
        .reset       (reset),
        .enable      ((state == IDLE) && !reset),
        .req_valid   (req_valid),
        .req_ready_c (req_ready),
        .grant_c     (grant_c),
        .accept_c    (accept_c)
    );

    // Select the granted requester's command
    always_comb begin
        sel_req_c = '0;
        if (grant_c) begin
            sel_req_c.write = req_write[1];
            sel_req_c.addr  = GLB_CFG_ADDR_WIDTH'(req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]);
            sel_req_c.wdata = GLB_CFG_DATA_WIDTH'(req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]);
        end else begin
            sel_req_c.write = req_write[0];
            sel_req_c.addr  = GLB_CFG_ADDR_WIDTH'(req_addr[ADDR_WIDTH-1:0]);
            sel_req_c.wdata = GLB_CFG_DATA_WIDTH'(req_wdata[DATA_WIDTH-1:0]);
        end
    end

    // Transaction FSM with registered chain and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gnt_q       <= 1'b0;
            tmo_cnt     <= '0;
            cfg_wr_en   <= 1'b0;
            cfg_wr_addr <= '0;
            cfg_wr_data <= '0;
            cfg_rd_en   <= 1'b0;
            cfg_rd_addr <= '0;
            resp_valid  <= '0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            cfg_wr_en  <= 1'b0;
            cfg_rd_en  <= 1'b0;
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        gnt_q   <= grant_c;
                        tmo_cnt <= '0;
                        if (sel_req_c.write) begin
                            cfg_wr_en   <= 1'b1;
                            cfg_wr_addr <= ADDR_WIDTH'(sel_req_c.addr);
                            cfg_wr_data <= DATA_WIDTH'(sel_req_c.wdata);
                            state       <= WR_DONE;
                        end else begin
                            cfg_rd_en   <= 1'b1;
                            cfg_rd_addr <= ADDR_WIDTH'(sel_req_c.addr);
                            state       <= RD_WAIT;
                        end
                    end
                end
                WR_DONE: begin
                    // Posted write: acknowledge as soon as it has left
                    resp_valid <= NUM_REQ'(glb_cfg_onehot(gnt_q));
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end
                RD_WAIT: begin
                    // Returning data beats the timeout in the same cycle
                    if (cfg_rd_data_valid) begin
                        resp_valid <= NUM_REQ'(glb_cfg_onehot(gnt_q));
                        resp_rdata <= cfg_rd_data;
                        resp_err   <= 1'b0;
                        tmo_cnt    <= '0;
                        state      <= IDLE;
                    end else if (tmo_cnt == TMO_W'(RD_TIMEOUT)) begin
                        resp_valid <= NUM_REQ'(glb_cfg_onehot(gnt_q));
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glb_cfg_chain_master.sv
// Scoreboard bench for glb_cfg_chain_master: stimulus pushes expected chain
// operations and responses, a negedge monitor pops and compares them.
module tb_glb_cfg_chain_master;

    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct {
        bit          write;
        logic [11:0] addr;
        logic [31:0] data;
    } cfg_exp_t;

    typedef struct {
        logic [1:0]  port;
        logic [31:0] rdata;
        logic        err;
        int          delta;
        bit          chk_data;
    } resp_exp_t;

    logic          clk;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_write;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]    req_ready;
    logic [1:0]    resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          cfg_wr_en;
    logic [AW-1:0] cfg_wr_addr;
    logic [DW-1:0] cfg_wr_data;
    logic          cfg_rd_en;
    logic [AW-1:0] cfg_rd_addr;
    logic          cfg_wr_clk_en;
    logic          cfg_rd_clk_en;
    logic [DW-1:0] cfg_rd_data;
    logic          cfg_rd_data_valid;

    cfg_exp_t  cfg_q[$];
    resp_exp_t resp_q[$];

    int  checks   = 0;
    int  errors   = 0;
    int  stim_tmo = 0;
    int  cyc      = 0;
    int  last_cfg = 0;
    bit  zero_chk = 0;
    bit  quiet    = 0;
    bit  done     = 0;
    bit  prev_wr  = 0;
    bit  prev_rd  = 0;

    glb_cfg_chain_master dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_ready         (req_ready),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .resp_err          (resp_err),
        .cfg_wr_en         (cfg_wr_en),
        .cfg_wr_addr       (cfg_wr_addr),
        .cfg_wr_data       (cfg_wr_data),
        .cfg_rd_en         (cfg_rd_en),
        .cfg_rd_addr       (cfg_rd_addr),
        .cfg_wr_clk_en     (cfg_wr_clk_en),
        .cfg_rd_clk_en     (cfg_rd_clk_en),
        .cfg_rd_data       (cfg_rd_data),
        .cfg_rd_data_valid (cfg_rd_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] arb_addr(input int j, input int i);
        return (j == 1) ? 12'(12'h410 + 4 * i) : 12'(12'h010 + 4 * i);
    endfunction

    function automatic logic [31:0] arb_data(input int j, input int i);
        return (j == 1) ? 32'(32'hB000_0000 + i) : 32'(32'hA000_0000 + i);
    endfunction

    // Monitor: all comparisons happen here on the falling edge
    always @(negedge clk) begin
        cfg_exp_t  ce;
        resp_exp_t re;
        cyc++;
        if (zero_chk) begin
            chk("zero_req_ready", 64'(req_ready), 64'd0);
            chk("zero_resp_valid", 64'(resp_valid), 64'd0);
            chk("zero_resp_rdata", 64'(resp_rdata), 64'd0);
            chk("zero_resp_err", 64'(resp_err), 64'd0);
            chk("zero_cfg_wr_en", 64'(cfg_wr_en), 64'd0);
            chk("zero_cfg_wr_addr", 64'(cfg_wr_addr), 64'd0);
            chk("zero_cfg_wr_data", 64'(cfg_wr_data), 64'd0);
            chk("zero_cfg_rd_en", 64'(cfg_rd_en), 64'd0);
            chk("zero_cfg_rd_addr", 64'(cfg_rd_addr), 64'd0);
            chk("clk_en_tied", 64'({cfg_wr_clk_en, cfg_rd_clk_en}), 64'd3);
        end
        if (quiet) begin
            chk("quiet_resp_valid", 64'(resp_valid), 64'd0);
        end else if (resp_valid != 2'b00) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                re = resp_q.pop_front();
                chk("resp_port", 64'(resp_valid), 64'(re.port));
                chk("resp_err", 64'(resp_err), 64'(re.err));
                chk("resp_latency", 64'(cyc - last_cfg), 64'(re.delta));
                if (re.chk_data) chk("resp_rdata", 64'(resp_rdata), 64'(re.rdata));
            end
        end
        if (cfg_wr_en || cfg_rd_en) begin
            chk("cfg_pulse_width", 64'({prev_wr && cfg_wr_en, prev_rd && cfg_rd_en}), 64'd0);
            if (cfg_q.size() == 0) begin
                chk("unexpected_cfg", 64'({cfg_wr_en, cfg_rd_en}), 64'd0);
            end else begin
                ce = cfg_q.pop_front();
                chk("cfg_kind", 64'({cfg_wr_en, cfg_rd_en}), ce.write ? 64'd2 : 64'd1);
                if (ce.write) begin
                    chk("cfg_wr_addr", 64'(cfg_wr_addr), 64'(ce.addr));
                    chk("cfg_wr_data", 64'(cfg_wr_data), 64'(ce.data));
                end else begin
                    chk("cfg_rd_addr", 64'(cfg_rd_addr), 64'(ce.addr));
                end
            end
            last_cfg = cyc;
        end
        prev_wr = cfg_wr_en;
        prev_rd = cfg_rd_en;
        if (done || cyc > 20000) begin
            if (!done) chk("watchdog_done", 64'd0, 64'd1);
            chk("stim_wait_timeouts", 64'(stim_tmo), 64'd0);
            chk("cfg_queue_empty", 64'(cfg_q.size()), 64'd0);
            chk("resp_queue_empty", 64'(resp_q.size()), 64'd0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic wait_accept(input int r);
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                @(posedge clk);
                #1;
                req_valid[r] = 1'b0;
                return;
            end
        end
        stim_tmo++;
    endtask

    task automatic issue(input int r, input bit wr, input logic [11:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        req_write[r]            = wr;
        req_addr[r*AW +: AW]    = a;
        req_wdata[r*DW +: DW]   = d;
        req_valid[r]            = 1'b1;
        wait_accept(r);
    endtask

    task automatic wait_cfg_rd();
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (cfg_rd_en) return;
        end
        stim_tmo++;
    endtask

    task automatic pulse_rd_data(input logic [31:0] d);
        #1;
        cfg_rd_data       = d;
        cfg_rd_data_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_rd_data_valid = 1'b0;
        cfg_rd_data       = '0;
    endtask

    // Stimulus and tile model
    initial begin
        int       cnt[2];
        logic [1:0] rdy;
        cnt[0] = 0;
        cnt[1] = 0;
        reset             = 1'b1;
        cfg_rd_data       = '0;
        cfg_rd_data_valid = 1'b0;
        req_write         = 2'b11;
        req_addr          = {arb_addr(1, 0), arb_addr(0, 0)};
        req_wdata         = {arb_data(1, 0), arb_data(0, 0)};
        req_valid         = 2'b11;

        for (int k = 0; k < 8; k++) begin
            cfg_q.push_back('{write: 1'b1, addr: arb_addr(k % 2, k / 2), data: arb_data(k % 2, k / 2)});
            resp_q.push_back('{port: 2'(1 << (k % 2)), rdata: 32'd0, err: 1'b0, delta: 1, chk_data: 1'b0});
        end

        repeat (2) @(posedge clk);
        #1 zero_chk = 1'b1;
        @(posedge clk);
        #1;
        zero_chk = 1'b0;
        reset    = 1'b0;

        // Arbitration: both requesters stream 4 writes each
        for (int n = 0; n < 1000 && (cnt[0] + cnt[1]) < 8; n++) begin
            @(negedge clk);
            rdy = req_ready;
            if (rdy != 2'b00) begin
                @(posedge clk);
                #1;
                for (int j = 0; j < 2; j++) begin
                    if (rdy[j]) begin
                        cnt[j]++;
                        if (cnt[j] == 4) begin
                            req_valid[j] = 1'b0;
                        end else begin
                            req_addr[j*AW +: AW]  = arb_addr(j, cnt[j]);
                            req_wdata[j*DW +: DW] = arb_data(j, cnt[j]);
                        end
                    end
                end
            end
        end
        if ((cnt[0] + cnt[1]) < 8) stim_tmo++;
        repeat (4) @(posedge clk);

        // Single write from requester 0
        cfg_q.push_back('{write: 1'b1, addr: 12'h104, data: 32'hA5A5_0001});
        resp_q.push_back('{port: 2'b01, rdata: 32'd0, err: 1'b0, delta: 1, chk_data: 1'b0});
        issue(0, 1'b1, 12'h104, 32'hA5A5_0001);
        repeat (4) @(posedge clk);

        // Read from requester 1, tile answers 7 cycles after cfg_rd_en
        cfg_q.push_back('{write: 1'b0, addr: 12'h208, data: 32'd0});
        resp_q.push_back('{port: 2'b10, rdata: 32'h1234_5678, err: 1'b0, delta: 8, chk_data: 1'b1});
        issue(1, 1'b0, 12'h208, 32'd0);
        wait_cfg_rd();
        repeat (7) @(posedge clk);
        pulse_rd_data(32'h1234_5678);
        repeat (4) @(posedge clk);

        // Out-of-range read never answered, then a stale answer in IDLE
        cfg_q.push_back('{write: 1'b0, addr: 12'hFFC, data: 32'd0});
        resp_q.push_back('{port: 2'b01, rdata: 32'd0, err: 1'b1, delta: 256, chk_data: 1'b1});
        issue(0, 1'b0, 12'hFFC, 32'd0);
        wait_cfg_rd();
        repeat (260) @(posedge clk);
        #1 quiet = 1'b1;
        pulse_rd_data(32'hDEAD_BEEF);
        repeat (3) @(posedge clk);
        #1 quiet = 1'b0;

        // Answer arrives exactly on the timeout cycle: data wins
        cfg_q.push_back('{write: 1'b0, addr: 12'h20C, data: 32'd0});
        resp_q.push_back('{port: 2'b10, rdata: 32'hCAFE_F00D, err: 1'b0, delta: 256, chk_data: 1'b1});
        issue(1, 1'b0, 12'h20C, 32'd0);
        wait_cfg_rd();
        repeat (255) @(posedge clk);
        pulse_rd_data(32'hCAFE_F00D);
        repeat (4) @(posedge clk);

        // Reset in the middle of a read: no response, late answer dropped
        cfg_q.push_back('{write: 1'b0, addr: 12'h30C, data: 32'd0});
        issue(1, 1'b0, 12'h30C, 32'd0);
        wait_cfg_rd();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        zero_chk = 1'b1;
        quiet    = 1'b1;
        @(posedge clk);
        #1 zero_chk = 1'b0;
        @(posedge clk);
        pulse_rd_data(32'h5555_AAAA);
        repeat (3) @(posedge clk);
        #1 quiet = 1'b0;

        repeat (5) @(posedge clk);
        #1 done = 1'b1;
    end

endmodule
